// File: rtl/oka_16bit_seq_ctrl.sv
// Sequencing controller for a time-multiplexed GF(2) Karatsuba multiplier.
// One external H-bit sub-multiplier is shared across z0, z2 and z1, then the result is recombined.
module oka_16bit_seq_ctrl #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*W-2:0]       y,
  output logic [W/2-1:0]       mul_a,
  output logic [W/2-1:0]       mul_b,
  input  logic [W-2:0]         mul_y,
  output logic                 mul_en,
  output logic                 busy,
  output logic [CNT_W-1:0]     ops_done
);

  localparam int H = W / 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P1   = 3'd2,
    S_P2   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-2:0]     r_z0;
  logic [W-2:0]     r_z2;
  logic [2*W-2:0]   r_y;
  logic [CNT_W-1:0] r_ops;
  logic             w_accept;
  logic             w_retire;
  logic [W-2:0]     w_mid;
  logic [2*W-2:0]   w_y;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_retire  = out_valid && out_ready;
  assign y         = r_y;
  assign ops_done  = r_ops;

  // Karatsuba recombination: middle term is z1 ^ z0 ^ z2, everything XOR-combined.
  assign w_mid = mul_y ^ r_z0 ^ r_z2;
  assign w_y   = {{W{1'b0}}, r_z0}
               ^ ({{W{1'b0}}, w_mid} << H)
               ^ ({{W{1'b0}}, r_z2} << W);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; DONE may jump straight to P0 when a new pair arrives on retire.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_P0;
        else          w_next = S_IDLE;
      end
      S_P0:   w_next = S_P1;
      S_P1:   w_next = S_P2;
      S_P2:   w_next = S_DONE;
      S_DONE: begin
        if (out_ready && in_valid) w_next = S_P0;
        else if (out_ready)        w_next = S_IDLE;
        else                       w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Sub-multiplier operand selection; held at zero outside P0..P2 for operand isolation.
  always_comb begin
    mul_a  = {H{1'b0}};
    mul_b  = {H{1'b0}};
    mul_en = 1'b0;
    case (r_state)
      S_P0: begin
        mul_a  = r_a[H-1:0];
        mul_b  = r_b[H-1:0];
        mul_en = 1'b1;
      end
      S_P1: begin
        mul_a  = r_a[W-1:H];
        mul_b  = r_b[W-1:H];
        mul_en = 1'b1;
      end
      S_P2: begin
        mul_a  = r_a[H-1:0] ^ r_a[W-1:H];
        mul_b  = r_b[H-1:0] ^ r_b[W-1:H];
        mul_en = 1'b1;
      end
      default: begin
        mul_a  = {H{1'b0}};
        mul_b  = {H{1'b0}};
        mul_en = 1'b0;
      end
    endcase
  end

  // Operand latch, partial products, result and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= {W{1'b0}};
      r_b   <= {W{1'b0}};
      r_z0  <= {(W-1){1'b0}};
      r_z2  <= {(W-1){1'b0}};
      r_y   <= {(2*W-1){1'b0}};
      r_ops <= {CNT_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_a <= a;
        r_b <= b;
      end
      case (r_state)
        S_P0:    r_z0 <= mul_y;
        S_P1:    r_z2 <= mul_y;
        S_P2:    r_y  <= w_y;
        default: r_y  <= r_y;
      endcase
      if (w_retire) begin
        r_ops <= r_ops + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_oka_16bit_seq_ctrl.sv
// Scoreboard bench: stimulus pushes reference carry-less products, a negedge monitor checks results.
module tb_oka_16bit_seq_ctrl;

  localparam int W     = 16;
  localparam int H     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [2*W-2:0]   y;
  logic [H-1:0]     mul_a;
  logic [H-1:0]     mul_b;
  logic [2*H-2:0]   mul_y;
  logic             mul_en;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  int model_cnt = 0;
  bit new_pres = 1'b1;
  logic [2*W-2:0] exp_q[$];
  int             acc_q[$];

  oka_16bit_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y), .mul_en(mul_en),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // Schoolbook shift-and-XOR product: the reference for both the sub-multiplier and the full result.
  function automatic logic [2*W-2:0] clmul(input logic [W-1:0] x, input logic [W-1:0] z);
    logic [2*W-2:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) r = r ^ ({{(W-1){1'b0}}, z} << i);
    end
    return r;
  endfunction

  always_comb begin
    logic [2*W-2:0] t;
    t = clmul({{H{1'b0}}, mul_a}, {{H{1'b0}}, mul_b});
    mul_y = t[2*H-2:0];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: records accepts, checks latency on each new presentation and y/ops_done on each retire.
  always @(negedge clk) begin
    if (!rst_n) begin
      new_pres = 1'b1;
    end else begin
      cyc++;
      if (in_valid && in_ready) begin
        exp_q.push_back(clmul(a, b));
        acc_q.push_back(cyc);
        n_acc++;
      end
      if (out_valid) begin
        if (new_pres) begin
          if (acc_q.size() == 0) chk("latency_noacc", 64'd1, 64'd0);
          else chk("latency", 64'(cyc - acc_q.pop_front()), 64'd4);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) chk("y_noexp", 64'd1, 64'd0);
          else chk("y", 64'(y), 64'(exp_q.pop_front()));
          chk("ops_done", 64'(ops_done), 64'(model_cnt));
          model_cnt = (model_cnt + 1) % (1 << CNT_W);
        end
      end
      new_pres = !out_valid || out_ready;
    end
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  // Issue one op and check the three sub-multiplier operand phases and, optionally, a known y.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit chk_y,
                        input logic [2*W-2:0] ey);
    bit ok = 1'b0;
    a = ta; b = tb; in_valid = 1'b1;
    wait_accept();
    @(negedge clk);
    chk("p0_mul", 64'({mul_en, mul_a, mul_b}), 64'({1'b1, ta[H-1:0], tb[H-1:0]}));
    @(negedge clk);
    chk("p1_mul", 64'({mul_en, mul_a, mul_b}), 64'({1'b1, ta[W-1:H], tb[W-1:H]}));
    @(negedge clk);
    chk("p2_mul", 64'({mul_en, mul_a, mul_b}),
        64'({1'b1, ta[H-1:0] ^ ta[W-1:H], tb[H-1:0] ^ tb[W-1:H]}));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    chk("out_valid_timeout", 64'(ok), 64'd1);
    chk("done_mul_en", 64'({mul_en, mul_a, mul_b}), 64'd0);
    if (chk_y) chk("y_const", 64'(y), 64'(ey));
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (!busy && !out_valid) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    logic [2*W-2:0] hy;
    int guard;
    int target;
    #1;
    chk("rst_state", 64'({in_ready, out_valid, mul_en, busy, ops_done, y, mul_a, mul_b}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, {CNT_W{1'b0}}, {(2*W-1){1'b0}}, 16'h0000}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted asynchronously while the op sits in P1.
    a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
    wait_accept();
    @(posedge clk); #3;
    chk("pre_rst_p1", 64'({busy, mul_en, mul_a, mul_b}), 64'({1'b1, 1'b1, 8'h12, 8'h56}));
    rst_n = 1'b0;
    #1;
    chk("mid_rst", 64'({out_valid, in_ready, mul_en, busy}), 64'({1'b0, 1'b1, 1'b0, 1'b0}));
    exp_q.delete(); acc_q.delete(); model_cnt = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h0003, 16'h0003, 1'b1, 31'h5);
    #1;
    chk("ops_done_one", 64'(ops_done), 64'd1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 31'h55555555);
    run_op(16'h8000, 16'h8000, 1'b1, 31'h40000000);
    run_op(16'h0100, 16'h0001, 1'b1, 31'h100);

    // Backpressure: result must sit unchanged in DONE while the sink stalls.
    out_ready = 1'b0;
    run_op(16'hA5C3, 16'h3C5A, 1'b1, clmul(16'hA5C3, 16'h3C5A));
    hy = y;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", 64'({y, out_valid, in_ready, ops_done}), 64'({hy, 1'b1, 1'b0, 4'd4}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_retire_once", 64'({out_valid, busy, ops_done}), 64'({1'b0, 1'b0, 4'd5}));
    chk("y_held_after", 64'(y), 64'(hy));

    // Random traffic: a back-to-back stretch, then random valid/ready stalls.
    target = n_acc + 1000;
    guard = 0;
    while (n_acc < target && guard < 20000) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (n_acc < target - 700) begin
        in_valid = 1'b1;
        out_ready = 1'b1;
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      guard++;
    end
    chk("rand_budget", 64'(guard < 20000), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("ops_done_final", 64'(ops_done), 64'(model_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
